// File: rtl/cpu_types_pkg.sv
// Shared types for the request unit: FSM state encoding and watchdog width.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } reqstate_t;

    localparam int unsigned WdogWidth = 8;

endpackage

// File: rtl/request_unit_if.sv
// Control-unit / memory handshake bundle for request_unit.
interface request_unit_if;

    logic cu_iREN;
    logic cu_dREN;
    logic cu_dWEN;
    logic cu_halt;
    logic ihit;
    logic dhit;
    logic iREN;
    logic dREN;
    logic dWEN;
    logic pcEN;
    logic halt;
    logic timeout_err;

    modport master (
        input  cu_iREN, cu_dREN, cu_dWEN, cu_halt, ihit, dhit,
        output iREN, dREN, dWEN, pcEN, halt, timeout_err
    );

    modport slave (
        output cu_iREN, cu_dREN, cu_dWEN, cu_halt, ihit, dhit,
        input  iREN, dREN, dWEN, pcEN, halt, timeout_err
    );

endinterface

// File: rtl/req_watchdog.sv
// Saturating data-access watchdog; expired fires in the cycle whose count-up
// would reach TIMEOUT_CYCLES.
module req_watchdog
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [WdogWidth-1:0] Limit = WdogWidth'(TIMEOUT_CYCLES);

    logic [WdogWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign expired = count_en && !clear && (count_q >= (Limit - 1'b1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/request_unit.sv
// Fetch/data/halt request sequencer. Define REQUEST_TIMEOUT_EN to add the
// data-access watchdog (req_watchdog) and a live timeout_err flag.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           CLK,
    input  logic           nRST,
    request_unit_if.master bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("TIMEOUT_CYCLES out of range 1..255");
    end

    reqstate_t state_q, state_d;
    logic      dren_q, dren_d;
    logic      dwen_q, dwen_d;
    logic      pcen_q, pcen;
    logic      ihit_ok;

`ifdef REQUEST_TIMEOUT_EN
    logic terr_q, terr_d;
    logic wd_clear, wd_cnt_en, wd_expired;

    req_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK      (CLK),
        .nRST     (nRST),
        .clear    (wd_clear),
        .count_en (wd_cnt_en),
        .expired  (wd_expired)
    );
`endif

    // An ihit in the cycle right after a PC advance belongs to the old PC.
    assign ihit_ok = bus.ihit & ~pcen_q;

    always_comb begin
        state_d = state_q;
        dren_d  = dren_q;
        dwen_d  = dwen_q;
        pcen    = 1'b0;
`ifdef REQUEST_TIMEOUT_EN
        terr_d    = terr_q;
        wd_clear  = 1'b0;
        wd_cnt_en = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                dren_d = 1'b0;
                dwen_d = 1'b0;
                if (ihit_ok) begin
                    if (bus.cu_dREN | bus.cu_dWEN) begin
                        state_d = DATA;
                        dwen_d  = bus.cu_dWEN;
                        dren_d  = bus.cu_dREN & ~bus.cu_dWEN;
`ifdef REQUEST_TIMEOUT_EN
                        wd_clear = 1'b1;
`endif
                    end else if (bus.cu_halt) begin
                        state_d = HALTED;
                    end else begin
                        pcen = 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.dhit) begin
                    pcen    = 1'b1;
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                    state_d = FETCH;
                end else begin
`ifdef REQUEST_TIMEOUT_EN
                    wd_cnt_en = 1'b1;
                    if (wd_expired) begin
                        state_d = HALTED;
                        dren_d  = 1'b0;
                        dwen_d  = 1'b0;
                        terr_d  = 1'b1;
                    end
`endif
                end
            end
            HALTED: begin
                dren_d = 1'b0;
                dwen_d = 1'b0;
            end
            default: begin
                state_d = HALTED;
                dren_d  = 1'b0;
                dwen_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
            pcen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dren_q  <= dren_d;
            dwen_q  <= dwen_d;
            pcen_q  <= pcen;
        end
    end

`ifdef REQUEST_TIMEOUT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            terr_q <= 1'b0;
        end else begin
            terr_q <= terr_d;
        end
    end
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.iREN = bus.cu_iREN & (state_q != DATA) & (state_q != HALTED);
    assign bus.dREN = dren_q;
    assign bus.dWEN = dwen_q;
    assign bus.pcEN = pcen;
    assign bus.halt = (state_q == HALTED);

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit (TIMEOUT_CYCLES=4); timeout expectations
// follow REQUEST_TIMEOUT_EN.
module tb_request_unit;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   failures = 0;

    request_unit_if bus ();

    request_unit #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    initial begin
        bus.cu_iREN = 1'b1;
        bus.cu_dREN = 1'b1;
        bus.cu_dWEN = 1'b0;
        bus.cu_halt = 1'b0;
        bus.ihit    = 1'b1;
        bus.dhit    = 1'b0;

        // Reset with a pending load request
        mid();
        chk("rst_dren", bus.dREN, 1'b0);
        chk("rst_dwen", bus.dWEN, 1'b0);
        chk("rst_halt", bus.halt, 1'b0);
        chk("rst_pcen", bus.pcEN, 1'b0);
        chk("rst_terr", bus.timeout_err, 1'b0);
        cyc();
        bus.ihit = 1'b0;
        bus.cu_dREN = 1'b0;
        nRST = 1'b1;
        mid();
        chk("post_rst_iren", bus.iREN, 1'b1);
        chk("post_rst_pcen", bus.pcEN, 1'b0);
        cyc();

        // ALU instruction, ihit held into the next cycle
        bus.ihit = 1'b1;
        mid();
        chk("alu_pcen", bus.pcEN, 1'b1);
        chk("alu_iren", bus.iREN, 1'b1);
        cyc();
        mid();
        chk("alu_pcen_next", bus.pcEN, 1'b0);
        chk("alu_stay_fetch", bus.iREN, 1'b1);
        chk("alu_dren", bus.dREN, 1'b0);
        cyc();

        // Load with three stall cycles
        bus.cu_dREN = 1'b1;
        mid();
        chk("ld_ihit_pcen", bus.pcEN, 1'b0);
        chk("ld_ihit_dren", bus.dREN, 1'b0);
        cyc();
        bus.ihit = 1'b0;
        bus.cu_dREN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("ld_stall_dren", bus.dREN, 1'b1);
            chk("ld_stall_dwen", bus.dWEN, 1'b0);
            chk("ld_stall_pcen", bus.pcEN, 1'b0);
            chk("ld_stall_iren", bus.iREN, 1'b0);
            cyc();
        end
        bus.dhit = 1'b1;
        mid();
        chk("ld_dhit_pcen", bus.pcEN, 1'b1);
        cyc();
        bus.dhit = 1'b0;
        mid();
        chk("ld_done_dren", bus.dREN, 1'b0);
        chk("ld_done_pcen", bus.pcEN, 1'b0);
        chk("ld_done_iren", bus.iREN, 1'b1);
        cyc();

        // Read+write conflict, then ihit and dhit together in DATA
        bus.ihit = 1'b1;
        bus.cu_dREN = 1'b1;
        bus.cu_dWEN = 1'b1;
        mid();
        chk("conf_ihit_pcen", bus.pcEN, 1'b0);
        cyc();
        bus.ihit = 1'b0;
        bus.cu_dREN = 1'b0;
        bus.cu_dWEN = 1'b0;
        mid();
        chk("conf_dwen", bus.dWEN, 1'b1);
        chk("conf_dren", bus.dREN, 1'b0);
        cyc();
        bus.ihit = 1'b1;
        bus.dhit = 1'b1;
        mid();
        chk("conf_dhit_pcen", bus.pcEN, 1'b1);
        cyc();
        mid();
        chk("conf_pcen_once", bus.pcEN, 1'b0);
        chk("conf_dwen_clr", bus.dWEN, 1'b0);
        chk("conf_fetch_iren", bus.iREN, 1'b1);
        cyc();
        bus.ihit = 1'b0;
        bus.dhit = 1'b0;
        mid();
        cyc();

        // Halt
        bus.ihit = 1'b1;
        bus.cu_halt = 1'b1;
        mid();
        chk("halt_ihit_pcen", bus.pcEN, 1'b0);
        chk("halt_not_yet", bus.halt, 1'b0);
        cyc();
        bus.cu_halt = 1'b0;
        bus.cu_dREN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("halted_halt", bus.halt, 1'b1);
            chk("halted_iren", bus.iREN, 1'b0);
            chk("halted_pcen", bus.pcEN, 1'b0);
            chk("halted_dren", bus.dREN, 1'b0);
            cyc();
        end
        nRST = 1'b0;
        #1;
        chk("halt_rst_clears", bus.halt, 1'b0);
        bus.cu_dREN = 1'b0;
        bus.ihit = 1'b0;
        cyc();
        nRST = 1'b1;
        mid();
        chk("halt_rst_iren", bus.iREN, 1'b1);
        cyc();

        // Store with dhit held low
        bus.ihit = 1'b1;
        bus.cu_dWEN = 1'b1;
        mid();
        cyc();
        bus.ihit = 1'b0;
        bus.cu_dWEN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("to_wait_dwen", bus.dWEN, 1'b1);
            chk("to_wait_terr", bus.timeout_err, 1'b0);
            chk("to_wait_halt", bus.halt, 1'b0);
            cyc();
        end
        mid();
`ifdef REQUEST_TIMEOUT_EN
        chk("to_terr", bus.timeout_err, 1'b1);
        chk("to_halt", bus.halt, 1'b1);
        chk("to_dwen", bus.dWEN, 1'b0);
        cyc();
`else
        chk("to_terr", bus.timeout_err, 1'b0);
        chk("to_halt", bus.halt, 1'b0);
        chk("to_dwen", bus.dWEN, 1'b1);
        cyc();
        bus.dhit = 1'b1;
        mid();
        chk("to_dhit_pcen", bus.pcEN, 1'b1);
        cyc();
        bus.dhit = 1'b0;
`endif
        nRST = 1'b0;
        #1;
        chk("to_rst_terr", bus.timeout_err, 1'b0);
        chk("to_rst_halt", bus.halt, 1'b0);
        cyc();
        nRST = 1'b1;
        cyc();

        // Reset in the middle of a DATA access
        bus.ihit = 1'b1;
        bus.cu_dREN = 1'b1;
        mid();
        cyc();
        bus.ihit = 1'b0;
        bus.cu_dREN = 1'b0;
        mid();
        chk("mid_rst_pre_dren", bus.dREN, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_rst_dren", bus.dREN, 1'b0);
        chk("mid_rst_dwen", bus.dWEN, 1'b0);
        cyc();
        nRST = 1'b1;
        mid();
        chk("mid_rst_iren", bus.iREN, 1'b1);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
